// File: rtl/rs_pkg.sv
// Shared widths, per-entry storage record and CDB bundle for the reservation station.
package rs_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 3;
    localparam int OPCODE_W  = 4;

    typedef struct packed {
        logic                  busy;
        logic [OPCODE_W-1:0]   opcode;
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic signed [XLEN-1:0] v_i;
        logic signed [XLEN-1:0] v_j;
        logic [ROB_IDX_W-1:0]  q_i;
        logic [ROB_IDX_W-1:0]  q_j;
        logic                  rdy_i;
        logic                  rdy_j;
    } rs_entry_t;

    typedef struct packed {
        logic                   valid;
        logic [ROB_IDX_W-1:0]   tag;
        logic signed [XLEN-1:0] value;
    } cdb_t;

    // An operand captures the broadcast only while it is still waiting on that tag.
    function automatic logic tag_hit(cdb_t cdb, logic rdy, logic [ROB_IDX_W-1:0] q);
        return cdb.valid && !rdy && (q == cdb.tag);
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: operand storage plus CDB tag compare.
// RS_CDB_BYPASS_EN lets an operand dispatched alongside a matching broadcast arrive ready.
module rs_entry
    import rs_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      alloc_en,
    input  logic      issue_clr,
    input  rs_entry_t alloc_data,
    input  cdb_t      cdb,
    output rs_entry_t state,
    output logic      eligible
);

    rs_entry_t alloc_next;
    logic      hit_i;
    logic      hit_j;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        alloc_next = alloc_data;
`ifdef RS_CDB_BYPASS_EN
        if (tag_hit(cdb, alloc_data.rdy_i, alloc_data.q_i)) begin
            alloc_next.v_i   = cdb.value;
            alloc_next.rdy_i = 1'b1;
        end
        if (tag_hit(cdb, alloc_data.rdy_j, alloc_data.q_j)) begin
            alloc_next.v_j   = cdb.value;
            alloc_next.rdy_j = 1'b1;
        end
`endif
    end

    assign hit_i    = state.busy && tag_hit(cdb, state.rdy_i, state.q_i);
    assign hit_j    = state.busy && tag_hit(cdb, state.rdy_j, state.q_j);
    assign eligible = state.busy && state.rdy_i && state.rdy_j;

    // NOTE: only the control bits are reset; payload fields are don't-care until busy is set.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state.busy  <= 1'b0;
            state.rdy_i <= 1'b0;
            state.rdy_j <= 1'b0;
        end else if (alloc_en) begin
            state <= alloc_next;
        end else if (issue_clr) begin
            state.busy <= 1'b0;
        end else begin
            if (hit_i) begin
                state.v_i   <= cdb.value;
                state.rdy_i <= 1'b1;
            end
            if (hit_j) begin
                state.v_j   <= cdb.value;
                state.rdy_j <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: lowest-free allocation, CDB wakeup, lowest-ready registered issue.
// Optional same-cycle dispatch/CDB capture is enabled with RS_CDB_BYPASS_EN.
module reservation_station
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    valid_input_in,
    input  logic                    fu_busy_in,
    input  logic [ROB_IDX_W-1:0]    Q_i_in,
    input  logic [ROB_IDX_W-1:0]    Q_j_in,
    input  logic signed [XLEN-1:0]  V_i_in,
    input  logic signed [XLEN-1:0]  V_j_in,
    input  logic                    i_ready,
    input  logic                    j_ready,
    input  logic [ROB_IDX_W-1:0]    rob_idx_in,
    input  logic [OPCODE_W-1:0]     opcode_in,
    input  logic                    cdb_valid_in,
    input  logic [ROB_IDX_W-1:0]    cdb_rob_idx_in,
    input  logic signed [XLEN-1:0]  cdb_value_in,
    output logic signed [XLEN-1:0]  rval1_out,
    output logic signed [XLEN-1:0]  rval2_out,
    output logic [OPCODE_W-1:0]     opcode_out,
    output logic [ROB_IDX_W-1:0]    rob_idx_out,
    output logic                    rs_free_for_input_out,
    output logic                    rs_output_valid_out
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    rs_entry_t              entries [NUM_ENTRIES];
    rs_entry_t              alloc_data;
    cdb_t                   cdb;
    logic [NUM_ENTRIES-1:0] busy;
    logic [NUM_ENTRIES-1:0] eligible;
    logic [NUM_ENTRIES-1:0] alloc_en;
    logic [NUM_ENTRIES-1:0] issue_clr;
    logic                   free_found;
    logic                   issue_found;
    logic [IDX_W-1:0]       issue_idx;

    assign cdb = '{valid: cdb_valid_in, tag: cdb_rob_idx_in, value: cdb_value_in};

    assign alloc_data = '{
        busy:    1'b1,
        opcode:  opcode_in,
        rob_idx: rob_idx_in,
        v_i:     V_i_in,
        v_j:     V_j_in,
        q_i:     Q_i_in,
        q_j:     Q_j_in,
        rdy_i:   i_ready,
        rdy_j:   j_ready
    };

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        rs_entry u_entry (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .alloc_en   (alloc_en[g]),
            .issue_clr  (issue_clr[g]),
            .alloc_data (alloc_data),
            .cdb        (cdb),
            .state      (entries[g]),
            .eligible   (eligible[g])
        );
        assign busy[g] = entries[g].busy;
    end

    // Both pickers look only at start-of-cycle state, so a slot freed by this
    // cycle's issue is not offered for allocation until the next cycle.
    always_comb begin
        alloc_en    = '0;
        issue_clr   = '0;
        free_found  = 1'b0;
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!busy[i] && !free_found) begin
                free_found  = 1'b1;
                alloc_en[i] = valid_input_in;
            end
            if (eligible[i] && !issue_found && !fu_busy_in) begin
                issue_found  = 1'b1;
                issue_clr[i] = 1'b1;
                issue_idx    = IDX_W'(i);
            end
        end
    end

    assign rs_free_for_input_out = free_found;

    always_ff @(posedge clk_in) begin
        if (rst_in || !issue_found) begin
            rs_output_valid_out <= 1'b0;
            rval1_out           <= '0;
            rval2_out           <= '0;
            opcode_out          <= '0;
            rob_idx_out         <= '0;
        end else begin
            rs_output_valid_out <= 1'b1;
            rval1_out           <= entries[issue_idx].v_i;
            rval2_out           <= entries[issue_idx].v_j;
            opcode_out          <= entries[issue_idx].opcode;
            rob_idx_out         <= entries[issue_idx].rob_idx;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus randomized
// traffic against an array-based reference model of the dispatch/wakeup/issue rules.
module tb_reservation_station;
    import rs_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_in;
    logic                    valid_input_in;
    logic                    fu_busy_in;
    logic [2:0]              Q_i_in;
    logic [2:0]              Q_j_in;
    logic signed [31:0]      V_i_in;
    logic signed [31:0]      V_j_in;
    logic                    i_ready;
    logic                    j_ready;
    logic [2:0]              rob_idx_in;
    logic [3:0]              opcode_in;
    logic                    cdb_valid_in;
    logic [2:0]              cdb_rob_idx_in;
    logic signed [31:0]      cdb_value_in;
    logic signed [31:0]      rval1_out;
    logic signed [31:0]      rval2_out;
    logic [3:0]              opcode_out;
    logic [2:0]              rob_idx_out;
    logic                    rs_free_for_input_out;
    logic                    rs_output_valid_out;

    reservation_station #(.NUM_ENTRIES(N)) dut (
        .clk_in                (clk),
        .rst_in                (rst_in),
        .valid_input_in        (valid_input_in),
        .fu_busy_in            (fu_busy_in),
        .Q_i_in                (Q_i_in),
        .Q_j_in                (Q_j_in),
        .V_i_in                (V_i_in),
        .V_j_in                (V_j_in),
        .i_ready               (i_ready),
        .j_ready               (j_ready),
        .rob_idx_in            (rob_idx_in),
        .opcode_in             (opcode_in),
        .cdb_valid_in          (cdb_valid_in),
        .cdb_rob_idx_in        (cdb_rob_idx_in),
        .cdb_value_in          (cdb_value_in),
        .rval1_out             (rval1_out),
        .rval2_out             (rval2_out),
        .opcode_out            (opcode_out),
        .rob_idx_out           (rob_idx_out),
        .rs_free_for_input_out (rs_free_for_input_out),
        .rs_output_valid_out   (rs_output_valid_out)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Issue port flattened as {valid, opcode, rob, rval1, rval2}.
    logic [71:0] obs;
    assign obs = {rs_output_valid_out, opcode_out, rob_idx_out, rval1_out, rval2_out};

    function automatic logic [71:0] pack_out(logic v, logic [3:0] op, logic [2:0] rob,
                                             logic signed [31:0] a, logic signed [31:0] b);
        return {v, op, rob, a, b};
    endfunction

    // Reference model state.
    bit                 m_busy [N];
    logic [3:0]         m_op   [N];
    logic [2:0]         m_rob  [N];
    logic signed [31:0] m_vi   [N];
    logic signed [31:0] m_vj   [N];
    logic [2:0]         m_qi   [N];
    logic [2:0]         m_qj   [N];
    bit                 m_ri   [N];
    bit                 m_rj   [N];
    logic [71:0]        exp_out;

    function automatic bit model_free();
        for (int i = 0; i < N; i++)
            if (!m_busy[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Applies one clock edge of the station's rules to the model using the current inputs.
    task automatic model_edge();
        int iss;
        int fr;
        iss = -1;
        fr  = -1;
        if (rst_in) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            exp_out = '0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (iss < 0 && !fu_busy_in && m_busy[i] && m_ri[i] && m_rj[i]) iss = i;
            if (fr < 0 && !m_busy[i]) fr = i;
        end
        exp_out = (iss >= 0) ? pack_out(1'b1, m_op[iss], m_rob[iss], m_vi[iss], m_vj[iss]) : '0;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && cdb_valid_in) begin
                if (!m_ri[i] && m_qi[i] == cdb_rob_idx_in) begin m_vi[i] = cdb_value_in; m_ri[i] = 1'b1; end
                if (!m_rj[i] && m_qj[i] == cdb_rob_idx_in) begin m_vj[i] = cdb_value_in; m_rj[i] = 1'b1; end
            end
        end
        if (iss >= 0) m_busy[iss] = 1'b0;
        if (valid_input_in && fr >= 0) begin
            m_busy[fr] = 1'b1;
            m_op[fr]   = opcode_in;
            m_rob[fr]  = rob_idx_in;
            m_vi[fr]   = V_i_in;
            m_vj[fr]   = V_j_in;
            m_qi[fr]   = Q_i_in;
            m_qj[fr]   = Q_j_in;
            m_ri[fr]   = i_ready;
            m_rj[fr]   = j_ready;
`ifdef RS_CDB_BYPASS_EN
            if (!i_ready && cdb_valid_in && Q_i_in == cdb_rob_idx_in) begin m_vi[fr] = cdb_value_in; m_ri[fr] = 1'b1; end
            if (!j_ready && cdb_valid_in && Q_j_in == cdb_rob_idx_in) begin m_vj[fr] = cdb_value_in; m_rj[fr] = 1'b1; end
`endif
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_input_in = 1'b0;
        Q_i_in = '0; Q_j_in = '0; V_i_in = '0; V_j_in = '0;
        i_ready = 1'b0; j_ready = 1'b0;
        rob_idx_in = '0; opcode_in = '0;
        cdb_valid_in = 1'b0; cdb_rob_idx_in = '0; cdb_value_in = '0;
    endtask

    task automatic dispatch(logic [3:0] op, logic [2:0] rob,
                            logic [2:0] qi, logic signed [31:0] vi, logic ir,
                            logic [2:0] qj, logic signed [31:0] vj, logic jr);
        valid_input_in = 1'b1;
        opcode_in = op; rob_idx_in = rob;
        Q_i_in = qi; V_i_in = vi; i_ready = ir;
        Q_j_in = qj; V_j_in = vj; j_ready = jr;
    endtask

    task automatic test_reset();
        drive_idle();
        fu_busy_in = 1'b0;
        rst_in = 1'b1;
        cycle();
        cycle();
        vectors++;
        if (obs !== 72'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want %h", obs, 72'h0);
        end
        rst_in = 1'b0;
        cycle();
        vectors++;
        if (rs_free_for_input_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_free: got %b want 1", rs_free_for_input_out);
        end
    endtask

    task automatic test_basic_issue();
        logic [71:0] want;
        dispatch(4'h2, 3'd3, 3'd0, 32'sd5, 1'b1, 3'd0, -32'sd3, 1'b1);
        cycle();
        drive_idle();
        vectors++;
        if (obs !== 72'h0) begin
            miscompares++;
            $display("FAIL basic_no_early_issue: got %h want %h", obs, 72'h0);
        end
        cycle();
        want = pack_out(1'b1, 4'h2, 3'd3, 32'sd5, -32'sd3);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL basic_issue: got %h want %h", obs, want);
        end
        cycle();
        vectors++;
        if ({rs_free_for_input_out, obs} !== {1'b1, 72'h0}) begin
            miscompares++;
            $display("FAIL basic_single_pulse: got free=%b out=%h want free=1 out=0", rs_free_for_input_out, obs);
        end
    endtask

    task automatic test_cdb_wakeup();
        logic [71:0] want;
        dispatch(4'h5, 3'd1, 3'd6, 32'sd0, 1'b0, 3'd0, 32'sd7, 1'b1);
        cycle();
        drive_idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            vectors++;
            if (obs !== 72'h0) begin
                miscompares++;
                $display("FAIL wakeup_wait_%0d: got %h want %h", k, obs, 72'h0);
            end
        end
        cdb_valid_in = 1'b1; cdb_rob_idx_in = 3'd6; cdb_value_in = 32'sd100;
        cycle();
        drive_idle();
        vectors++;
        if (obs !== 72'h0) begin
            miscompares++;
            $display("FAIL wakeup_same_cycle: got %h want %h", obs, 72'h0);
        end
        cycle();
        want = pack_out(1'b1, 4'h5, 3'd1, 32'sd100, 32'sd7);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL wakeup_issue: got %h want %h", obs, want);
        end
        cycle();
    endtask

    task automatic test_full_stall();
        logic [71:0] want;
        fu_busy_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dispatch(4'(k + 8), 3'(k), 3'd0, 32'(k * 10), 1'b1, 3'd0, 32'(k + 1), 1'b1);
            cycle();
        end
        vectors++;
        if (rs_free_for_input_out !== 1'b0) begin
            miscompares++;
            $display("FAIL full_flag: got %b want 0", rs_free_for_input_out);
        end
        dispatch(4'hf, 3'd7, 3'd0, 32'sd77, 1'b1, 3'd0, 32'sd77, 1'b1);
        cycle();
        vectors++;
        if ({rs_free_for_input_out, obs} !== {1'b0, 72'h0}) begin
            miscompares++;
            $display("FAIL full_stall: got free=%b out=%h want free=0 out=0", rs_free_for_input_out, obs);
        end
        drive_idle();
        fu_busy_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            want = pack_out(1'b1, 4'(k + 8), 3'(k), 32'(k * 10), 32'(k + 1));
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL full_drain_%0d: got %h want %h", k, obs, want);
            end
        end
        cycle();
        vectors++;
        if ({rs_free_for_input_out, obs} !== {1'b1, 72'h0}) begin
            miscompares++;
            $display("FAIL full_fifth_dropped: got free=%b out=%h want free=1 out=0", rs_free_for_input_out, obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  order [5];
        logic [71:0] want;
        order = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd3};
        fu_busy_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dispatch(4'h1, 3'(k), 3'd0, 32'(k), 1'b1, 3'd0, -32'(k), 1'b1);
            cycle();
        end
        fu_busy_in = 1'b0;
        dispatch(4'h3, 3'd5, 3'd0, 32'sd50, 1'b1, 3'd0, 32'sd60, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k == 1) drive_idle();
            if (order[k] == 3'd5) want = pack_out(1'b1, 4'h3, 3'd5, 32'sd50, 32'sd60);
            else                  want = pack_out(1'b1, 4'h1, order[k], 32'(order[k]), -32'(order[k]));
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL b2b_issue_%0d: got %h want %h", k, obs, want);
            end
        end
        cycle();
        vectors++;
        if ({rs_free_for_input_out, obs} !== {1'b1, 72'h0}) begin
            miscompares++;
            $display("FAIL b2b_single_accept: got free=%b out=%h want free=1 out=0", rs_free_for_input_out, obs);
        end
    endtask

    task automatic test_reset_flush();
        fu_busy_in = 1'b1;
        dispatch(4'h4, 3'd2, 3'd0, 32'sd11, 1'b1, 3'd0, 32'sd12, 1'b1);
        cycle();
        dispatch(4'h4, 3'd4, 3'd0, 32'sd13, 1'b1, 3'd0, 32'sd14, 1'b1);
        cycle();
        rst_in = 1'b1;
        fu_busy_in = 1'b0;
        cdb_valid_in = 1'b1; cdb_rob_idx_in = 3'd2; cdb_value_in = 32'sd99;
        cycle();
        rst_in = 1'b0;
        drive_idle();
        vectors++;
        if ({rs_free_for_input_out, obs} !== {1'b1, 72'h0}) begin
            miscompares++;
            $display("FAIL flush_reset: got free=%b out=%h want free=1 out=0", rs_free_for_input_out, obs);
        end
        for (int k = 0; k < 4; k++) begin
            cycle();
            vectors++;
            if (obs !== 72'h0) begin
                miscompares++;
                $display("FAIL flush_no_issue_%0d: got %h want %h", k, obs, 72'h0);
            end
        end
    endtask

    task automatic test_bypass();
        dispatch(4'h6, 3'd2, 3'd1, 32'sd0, 1'b0, 3'd0, 32'sd2, 1'b1);
        cdb_valid_in = 1'b1; cdb_rob_idx_in = 3'd1; cdb_value_in = 32'sd9;
        cycle();
        drive_idle();
`ifdef RS_CDB_BYPASS_EN
        cycle();
        vectors++;
        if (obs !== pack_out(1'b1, 4'h6, 3'd2, 32'sd9, 32'sd2)) begin
            miscompares++;
            $display("FAIL bypass_issue: got %h want %h", obs, pack_out(1'b1, 4'h6, 3'd2, 32'sd9, 32'sd2));
        end
`else
        for (int k = 0; k < 4; k++) begin
            cycle();
            vectors++;
            if (obs !== 72'h0) begin
                miscompares++;
                $display("FAIL no_bypass_wait_%0d: got %h want %h", k, obs, 72'h0);
            end
        end
`endif
        rst_in = 1'b1;
        cycle();
        rst_in = 1'b0;
    endtask

    task automatic test_random();
        logic [71:0] want;
        rst_in = 1'b1;
        drive_idle();
        cycle();
        rst_in = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_in         = ($urandom_range(0, 199) == 0);
            fu_busy_in     = ($urandom_range(0, 3) == 0);
            valid_input_in = $urandom_range(0, 1);
            opcode_in      = 4'($urandom);
            rob_idx_in     = 3'($urandom);
            Q_i_in         = 3'($urandom);
            Q_j_in         = 3'($urandom);
            V_i_in         = $urandom;
            V_j_in         = $urandom;
            i_ready        = $urandom_range(0, 1);
            j_ready        = $urandom_range(0, 1);
            cdb_valid_in   = $urandom_range(0, 1);
            cdb_rob_idx_in = 3'($urandom);
            cdb_value_in   = $urandom;
            cycle();
            want = exp_out;
            vectors++;
            if (obs !== want) begin
                miscompares++;
                $display("FAIL rand_issue_c%0d: got %h want %h", c, obs, want);
            end
            vectors++;
            if (rs_free_for_input_out !== model_free()) begin
                miscompares++;
                $display("FAIL rand_free_c%0d: got %b want %b", c, rs_free_for_input_out, model_free());
            end
        end
        drive_idle();
        rst_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        fu_busy_in = 1'b0;
        drive_idle();
        exp_out = '0;
        for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        test_reset();
        test_basic_issue();
        test_cdb_wakeup();
        test_full_stall();
        test_back_to_back();
        test_reset_flush();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4: number of RS entries (power of two, 2..8).
REQ-002 SHALL have clk_in, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have rst_in, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have valid_input_in, input, 1: dispatch request this cycle.
REQ-005 SHALL have fu_busy_in, input, 1: downstream functional unit cannot accept an issue.
REQ-006 SHALL have Q_i_in / Q_j_in, input, 3 each: ROB tag producing operand i / j (8-entry ROB).
REQ-007 SHALL have V_i_in / V_j_in, input, signed 32 each: operand values, meaningful when the matching ready bit is 1.
REQ-008 SHALL have i_ready / j_ready, input, 1 each: operand i / j value is valid at dispatch.
REQ-009 SHALL have rob_idx_in, input, 3: destination ROB entry; opcode_in, input, 4: FU opcode.
REQ-010 SHALL have cdb_valid_in, input, 1; cdb_rob_idx_in, input, 3; cdb_value_in, input, signed 32: common-data-bus broadcast.
REQ-011 SHALL have rval1_out / rval2_out, output, signed 32: issued operands i / j.
REQ-012 SHALL have opcode_out, output, 4; rob_idx_out, output, 3: issued opcode and destination tag.
REQ-013 SHALL have rs_free_for_input_out, output, 1: at least one entry free.
REQ-014 SHALL have rs_output_valid_out, output, 1: issue outputs valid this cycle.

Function
REQ-015 Per-entry state SHALL be: busy, opcode, rob_idx, V_i, V_j, Q_i, Q_j, rdy_i, rdy_j.
REQ-016 rs_free_for_input_out SHALL be combinational, high iff any entry is not busy; it ignores entries freed in the current cycle.
REQ-017 On valid_input_in && rs_free_for_input_out, the lowest-index free entry SHALL be allocated at the edge; dispatch while full SHALL be ignored with no state change.
REQ-018 On allocation, an operand with ready=1 SHALL store V and set rdy; with ready=0 it SHALL store Q and clear rdy.
REQ-019 Each cycle, for every busy entry with a non-ready operand whose Q equals cdb_rob_idx_in while cdb_valid_in=1, the entry SHALL latch cdb_value_in and set rdy; both operands may capture in the same cycle.
REQ-020 An entry SHALL be eligible for issue when busy, rdy_i and rdy_j are all set at the start of the cycle; wakeup and issue are not combined in one cycle.
REQ-021 When fu_busy_in=0 and any entry is eligible, the lowest-index eligible entry SHALL be issued: outputs registered at the edge, rs_output_valid_out=1 for exactly one cycle, and the entry cleared to not-busy at the same edge.
REQ-022 When nothing is issued, rs_output_valid_out SHALL be 0 and rval1_out, rval2_out, opcode_out, rob_idx_out SHALL be 0.
REQ-023 Latency: dispatch with both operands ready at edge N SHALL give rs_output_valid_out=1 after edge N+1 if fu_busy_in=0.
REQ-024 Allocation and issue in the same cycle SHALL both occur; a full RS issuing this cycle accepts a dispatch next cycle.
REQ-025 fu_busy_in=1 SHALL stall issue; entries keep their state and keep snooping the CDB.

Reset
REQ-026 With rst_in=1 at an edge, all entries SHALL become not-busy, all outputs 0, and rs_free_for_input_out 1 from the next cycle; reset takes priority over dispatch, CDB and issue, and discards in-flight entries.

Configuration
REQ-027 Macro RS_CDB_BYPASS_EN defined: a non-ready operand dispatched in the same cycle as a CDB broadcast with a matching tag SHALL be captured as ready with cdb_value_in.
REQ-028 RS_CDB_BYPASS_EN undefined: no same-cycle capture; that operand waits as non-ready and upstream SHALL forward the value instead.

Structure
REQ-029 Package rs_pkg SHALL hold XLEN=32, ROB_IDX_W=3, OPCODE_W=4 and the rs_entry_t struct typedef.
REQ-030 One sub-module, rs_entry (single-entry storage plus CDB compare), SHALL be instantiated NUM_ENTRIES times; free and issue selection stay in the top module.

Verification
REQ-031 Reset, then dispatch op 4'h2, V_i=5, V_j=-3, both ready, rob 3, fu_busy_in=0 -> one cycle later rval1=5, rval2=-3, opcode_out=2, rob_idx_out=3, rs_output_valid_out=1 for one cycle.
REQ-032 Dispatch Q_i=6 not ready, V_j=7 ready -> no issue; CDB tag 6 value 100 -> issue the next cycle with rval1=100, rval2=7.
REQ-033 Four ready dispatches while fu_busy_in=1 -> rs_free_for_input_out=0 and a fifth dispatch is ignored; release fu_busy_in -> four issues in entry order 0..3.
REQ-034 Full RS with fu_busy_in=0 and a dispatch in the same cycle -> one issue, and the new entry is accepted the cycle after the free slot appears.
REQ-035 Assert rst_in with 2 pending entries -> outputs 0, rs_free_for_input_out=1, no later issue of the dropped entries.
REQ-036 Dispatch Q_i=1 not ready in the same cycle as CDB tag 1 value 9 -> issues with rval1=9 when RS_CDB_BYPASS_EN is defined; never issues when it is undefined.
